wb_regfile: RTL and testbench

Writeback stage and architectural register file for the five-stage pipelined CPU. It consumes the MEM/WB pipeline register outputs, selects between the ALU result and the loaded memory word, commits that value into the register file on the clock edge, and serves the two combinational read ports used by the ID stage. It also keeps a retired-instruction counter for bring-up and performance checks.

---
 rtl/wb_regfile.sv | 106 ++++++++++
 tb/tb_wb_regfile.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Writeback stage and architectural register file. Selects the
//            ALU result or load data, commits it on the rising clock edge,
//            serves two combinational read ports and counts retired
//            instructions. Register 0 reads as zero and ignores writes.
// Options  : WB_BYPASS_EN - when defined, a read of the register being
//            committed this cycle returns the new value (write-before-read).
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 16,
  parameter int ADDR_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              wb_valid,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [31:0]       retire_count
);

  localparam logic [ADDR_W-1:0] c_ZERO_IDX = '0;

  logic [DATA_W-1:0] r_regs [REG_N];
  logic [31:0]       r_retire_count;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_we;
  logic [DATA_W-1:0] w_rd_data_a;
  logic [DATA_W-1:0] w_rd_data_b;

  // Writeback mux; runs for bubbles too so forwarding always sees a value.
  always_comb begin
    w_wb_data = mem_to_reg ? mem_data : alu_result;
  end

  // Commit strobe: real instruction, writes a register, destination not r0.
  assign w_wb_we = wb_valid & reg_write & (wb_addr != c_ZERO_IDX);

  // Register array: cleared by reset, one entry updated per committing edge.
  // Entry 0 is never written because the strobe excludes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_N; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_we) begin
      r_regs[wb_addr] <= w_wb_data;
    end
  end

  // Retired-instruction counter; every valid MEM/WB slot counts, wraps freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retire_count <= '0;
    end else if (wb_valid) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  // Read port A: array lookup, optional same-cycle bypass, r0 forced to zero.
  // The bypass is gated by reset so reads stay zero while reset is held.
  always_comb begin
    w_rd_data_a = r_regs[rd_addr_a];
`ifdef WB_BYPASS_EN
    if (rst && w_wb_we && (rd_addr_a == wb_addr)) begin
      w_rd_data_a = w_wb_data;
    end
`endif
    if (rd_addr_a == c_ZERO_IDX) begin
      w_rd_data_a = '0;
    end
  end

  // Read port B: identical to port A and fully independent of it.
  always_comb begin
    w_rd_data_b = r_regs[rd_addr_b];
`ifdef WB_BYPASS_EN
    if (rst && w_wb_we && (rd_addr_b == wb_addr)) begin
      w_rd_data_b = w_wb_data;
    end
`endif
    if (rd_addr_b == c_ZERO_IDX) begin
      w_rd_data_b = '0;
    end
  end

  assign rd_data_a    = w_rd_data_a;
  assign rd_data_b    = w_rd_data_b;
  assign wb_data      = w_wb_data;
  assign wb_we        = w_wb_we;
  assign retire_count = r_retire_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Directed self-checking bench for wb_regfile. Expected values are
//            hand-computed; the same-cycle hazard expectation follows
//            WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  localparam int DATA_W = 16;
  localparam int REG_N  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              wb_valid;
  logic              reg_write;
  logic              mem_to_reg;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;
  logic [31:0]       retire_count;

  int n_checks;
  int n_errors;

  wb_regfile #(
    .DATA_W(DATA_W),
    .REG_N (REG_N),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_valid    (wb_valid),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .wb_addr     (wb_addr),
    .alu_result  (alu_result),
    .mem_data    (mem_data),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .wb_data     (wb_data),
    .wb_we       (wb_we),
    .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Safety net in case the run never reaches its summary.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    wb_valid   = 1'b1;
    reg_write  = 1'b1;
    mem_to_reg = 1'b0;
    wb_addr    = 4'd5;
    alu_result = 16'h5555;
    mem_data   = 16'hAAAA;
    rd_addr_a  = 4'd5;
    rd_addr_b  = 4'd5;
    #1 rst = 1'b0;

    // ---- Reset held with valid writes toggling: nothing commits or counts
    for (int i = 0; i < 4; i++) begin
      reg_write = i[0];
      tick();
    end
    for (int a = 0; a < REG_N; a++) begin
      rd_addr_a = a[ADDR_W-1:0];
      rd_addr_b = 4'(REG_N - 1 - a);
      #1;
      check("rst_rd_a", {16'h0, rd_data_a}, 32'h0);
      check("rst_rd_b", {16'h0, rd_data_b}, 32'h0);
    end
    check("rst_retire", retire_count, 32'h0);

    // ---- Release reset, retire three non-writing instructions
    rst       = 1'b1;
    reg_write = 1'b0;
    wb_valid  = 1'b1;
    tick(); tick(); tick();
    wb_valid = 1'b0;
    #1;
    check("retire_3", retire_count, 32'd3);

    // ---- ALU writeback to r5
    wb_valid   = 1'b1;
    reg_write  = 1'b1;
    mem_to_reg = 1'b0;
    wb_addr    = 4'd5;
    alu_result = 16'h1234;
    mem_data   = 16'hBEEF;
    #1;
    check("alu_wb_data", {16'h0, wb_data}, 32'h1234);
    check("alu_wb_we", {31'h0, wb_we}, 32'h1);
    tick();
    // ---- Load writeback to r6, read back r5 from the array
    mem_to_reg = 1'b1;
    wb_addr    = 4'd6;
    rd_addr_a  = 4'd5;
    rd_addr_b  = 4'd0;
    #1;
    check("mem_wb_data", {16'h0, wb_data}, 32'hBEEF);
    check("rd_r5", {16'h0, rd_data_a}, 32'h1234);
    tick();
    wb_valid  = 1'b0;
    rd_addr_a = 4'd6;
    rd_addr_b = 4'd5;
    #1;
    check("rd_r6_a", {16'h0, rd_data_a}, 32'hBEEF);
    check("rd_r5_b", {16'h0, rd_data_b}, 32'h1234);
    check("retire_5", retire_count, 32'd5);

    // ---- Register 0 guard
    wb_valid   = 1'b1;
    reg_write  = 1'b1;
    mem_to_reg = 1'b0;
    wb_addr    = 4'd0;
    alu_result = 16'hFFFF;
    rd_addr_a  = 4'd0;
    rd_addr_b  = 4'd0;
    #1;
    check("r0_we", {31'h0, wb_we}, 32'h0);
    check("r0_wb_data", {16'h0, wb_data}, 32'hFFFF);
    check("r0_same_a", {16'h0, rd_data_a}, 32'h0);
    check("r0_same_b", {16'h0, rd_data_b}, 32'h0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("r0_next_a", {16'h0, rd_data_a}, 32'h0);
    check("retire_6", retire_count, 32'd6);

    // ---- Bubble with reg_write set: no commit, no count
    wb_valid   = 1'b0;
    reg_write  = 1'b1;
    wb_addr    = 4'd3;
    alu_result = 16'h00AA;
    rd_addr_a  = 4'd3;
    #1;
    check("bubble_we", {31'h0, wb_we}, 32'h0);
    tick();
    check("bubble_r3", {16'h0, rd_data_a}, 32'h0);
    check("bubble_retire", retire_count, 32'd6);

    // ---- Same-cycle hazard on r7
    wb_valid   = 1'b1;
    reg_write  = 1'b1;
    mem_to_reg = 1'b0;
    wb_addr    = 4'd7;
    alu_result = 16'h0001;
    tick();
    alu_result = 16'h0002;
    rd_addr_a  = 4'd7;
    rd_addr_b  = 4'd7;
    #1;
`ifdef WB_BYPASS_EN
    check("hazard_a", {16'h0, rd_data_a}, 32'h0002);
    check("hazard_b", {16'h0, rd_data_b}, 32'h0002);
`else
    check("hazard_a", {16'h0, rd_data_a}, 32'h0001);
    check("hazard_b", {16'h0, rd_data_b}, 32'h0001);
`endif
    tick();
    wb_valid = 1'b0;
    #1;
    check("hazard_next_a", {16'h0, rd_data_a}, 32'h0002);
    check("hazard_next_b", {16'h0, rd_data_b}, 32'h0002);
    check("retire_8", retire_count, 32'd8);

    // ---- Counter wrap
    force dut.r_retire_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_retire_count;
    #1;
    check("preset_count", retire_count, 32'hFFFF_FFFE);
    wb_valid  = 1'b1;
    reg_write = 1'b0;
    tick();
    check("count_ffff", retire_count, 32'hFFFF_FFFF);
    tick();
    check("count_wrap", retire_count, 32'h0);
    tick();
    check("count_after_wrap", retire_count, 32'd1);

    // ---- Asynchronous reset mid-cycle with a write pending to r9
    reg_write  = 1'b1;
    wb_addr    = 4'd9;
    alu_result = 16'h9999;
    rd_addr_a  = 4'd5;
    rd_addr_b  = 4'd9;
    #1;
    check("pre_rst_r5", {16'h0, rd_data_a}, 32'h1234);
    #1;
    rst = 1'b0;
    #1;
    check("async_rd_a", {16'h0, rd_data_a}, 32'h0);
    check("async_rd_b", {16'h0, rd_data_b}, 32'h0);
    check("async_retire", retire_count, 32'h0);
    tick();
    wb_valid = 1'b0;
    rst      = 1'b1;
    rd_addr_a = 4'd9;
    rd_addr_b = 4'd6;
    #1;
    check("lost_write_r9", {16'h0, rd_data_a}, 32'h0);
    check("cleared_r6", {16'h0, rd_data_b}, 32'h0);
    tick();
    check("post_rst_retire", retire_count, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
